// File: rtl/pkt_classifier_pipe.sv
// Pipelined source/target header classifier with a skid buffer and saturating per-type counters.
// Optional build macro PKT_CLASSIFIER_DROP_ERR_EN: ERR headers are counted but never emitted.

package packet_pkg;
  typedef enum logic [1:0] {
    SDP = 2'd0,
    MDP = 2'd1,
    BDP = 2'd2,
    ERR = 2'd3
  } p_type;
endpackage

module pkt_classifier_pipe
  import packet_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_PORTS-1:0] in_source,
  input  logic [NUM_PORTS-1:0] in_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_PORTS-1:0] out_source,
  output logic [NUM_PORTS-1:0] out_target,
  output p_type                out_type,
  output logic                 out_pkt_ok,
  output logic [NUM_PORTS-1:0] out_dest_mask,
  input  logic                 clr_stats,
  output logic [CNT_WIDTH-1:0] cnt_sdp,
  output logic [CNT_WIDTH-1:0] cnt_mdp,
  output logic [CNT_WIDTH-1:0] cnt_bdp,
  output logic [CNT_WIDTH-1:0] cnt_err
);

  typedef struct packed {
    logic [NUM_PORTS-1:0] source;
    logic [NUM_PORTS-1:0] target;
    logic [NUM_PORTS-1:0] dest;
    p_type                ptype;
    logic                 ok;
  } entry_t;

  localparam entry_t RST_ENTRY = '{source: '0, target: '0, dest: '0, ptype: ERR, ok: 1'b0};

  function automatic int popcnt(input logic [NUM_PORTS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  entry_t     cls;
  p_type      cls_type;
  logic [1:0] cls_idx;

  // BDP is tested before SDP/MDP so that a 2-port switch maps popcount 2 to BDP.
  always_comb begin
    cls_type = ERR;
    if (popcnt(in_source) == 1 && in_target != '0) begin
      if (popcnt(in_target) == NUM_PORTS) cls_type = BDP;
      else if (popcnt(in_target) == 1)    cls_type = SDP;
      else                                 cls_type = MDP;
      if (cls_type != BDP && (in_target & in_source) != '0) cls_type = ERR;
    end
    cls.source = in_source;
    cls.target = in_target;
    cls.ptype  = cls_type;
    cls.ok     = (cls_type != ERR);
    cls.dest   = (cls_type != ERR) ? (in_target & ~in_source) : '0;
    cls_idx    = cls_type;
  end

  entry_t out_q, skid_q;
  logic   out_vld, skid_vld;
  logic   accept, wr;

  assign accept = in_valid & in_ready;
`ifdef PKT_CLASSIFIER_DROP_ERR_EN
  assign wr = accept & cls.ok;
`else
  assign wr = accept;
`endif

  // Skid only fills while the output is stalled, so skid_vld implies out_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_q    <= RST_ENTRY;
      skid_q   <= RST_ENTRY;
    end else if (!out_vld || out_ready) begin
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else if (wr) begin
        out_q   <= cls;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (wr) begin
      skid_q   <= cls;
      skid_vld <= 1'b1;
    end
  end

  assign in_ready      = ~skid_vld;
  assign out_valid     = out_vld;
  assign out_source    = out_q.source;
  assign out_target    = out_q.target;
  assign out_type      = out_q.ptype;
  assign out_pkt_ok    = out_q.ok;
  assign out_dest_mask = out_q.dest;

  logic [CNT_WIDTH-1:0] cnt_q [4];

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (accept && cnt_q[cls_idx] != {CNT_WIDTH{1'b1}}) begin
      cnt_q[cls_idx] <= cnt_q[cls_idx] + 1'b1;
    end
  end

  assign cnt_sdp = cnt_q[0];
  assign cnt_mdp = cnt_q[1];
  assign cnt_bdp = cnt_q[2];
  assign cnt_err = cnt_q[3];

endmodule

// File: tb/tb_pkt_classifier_pipe.sv
// Directed bench for pkt_classifier_pipe: classification table, backpressure, throughput,
// counter saturation/clear, reset flush, and a 2-port instance.
module tb_pkt_classifier_pipe;
  import packet_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, out_ready = 1'b0, clr_stats = 1'b0;
  logic [3:0]  in_source = '0, in_target = '0;
  logic        in_ready, out_valid, out_pkt_ok;
  logic [3:0]  out_source, out_target, out_dest_mask;
  p_type       out_type;
  logic [15:0] cnt_sdp, cnt_mdp, cnt_bdp, cnt_err;

  logic        s_in_ready, s_out_valid, s_out_pkt_ok;
  logic [3:0]  s_out_source, s_out_target, s_out_dest_mask;
  p_type       s_out_type;
  logic [3:0]  s_cnt_sdp, s_cnt_mdp, s_cnt_bdp, s_cnt_err;

  logic        d2_in_valid = 1'b0, d2_out_ready = 1'b1;
  logic [1:0]  d2_in_source = '0, d2_in_target = '0;
  logic        d2_in_ready, d2_out_valid, d2_out_pkt_ok;
  logic [1:0]  d2_out_source, d2_out_target, d2_out_dest_mask;
  p_type       d2_out_type;
  logic [15:0] d2_cnt_sdp, d2_cnt_mdp, d2_cnt_bdp, d2_cnt_err;

  pkt_classifier_pipe #(.NUM_PORTS(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_source(in_source), .in_target(in_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_source(out_source), .out_target(out_target),
    .out_type(out_type), .out_pkt_ok(out_pkt_ok), .out_dest_mask(out_dest_mask),
    .clr_stats(clr_stats), .cnt_sdp(cnt_sdp), .cnt_mdp(cnt_mdp),
    .cnt_bdp(cnt_bdp), .cnt_err(cnt_err));

  pkt_classifier_pipe #(.NUM_PORTS(4), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_source(in_source), .in_target(in_target), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_source(s_out_source), .out_target(s_out_target),
    .out_type(s_out_type), .out_pkt_ok(s_out_pkt_ok), .out_dest_mask(s_out_dest_mask),
    .clr_stats(clr_stats), .cnt_sdp(s_cnt_sdp), .cnt_mdp(s_cnt_mdp),
    .cnt_bdp(s_cnt_bdp), .cnt_err(s_cnt_err));

  pkt_classifier_pipe #(.NUM_PORTS(2), .CNT_WIDTH(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_source(d2_in_source), .in_target(d2_in_target), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready), .out_source(d2_out_source), .out_target(d2_out_target),
    .out_type(d2_out_type), .out_pkt_ok(d2_out_pkt_ok), .out_dest_mask(d2_out_dest_mask),
    .clr_stats(clr_stats), .cnt_sdp(d2_cnt_sdp), .cnt_mdp(d2_cnt_mdp),
    .cnt_bdp(d2_cnt_bdp), .cnt_err(d2_cnt_err));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    d2_in_valid = 1'b0;
    clr_stats = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_cnts(input string name, input int s, input int m, input int b, input int e);
    chk({name, "_sdp"}, 32'(cnt_sdp), s);
    chk({name, "_mdp"}, 32'(cnt_mdp), m);
    chk({name, "_bdp"}, 32'(cnt_bdp), b);
    chk({name, "_err"}, 32'(cnt_err), e);
  endtask

  typedef struct {
    logic [3:0] src;
    logic [3:0] tgt;
    p_type      typ;
    logic [3:0] dest;
  } vec_t;

  vec_t vecs [10];

  logic [3:0] hs [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] ht [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic       bp_ordy [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       bp_rdy  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       bp_vld  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  int         bp_idx  [7] = '{0, 0, 0, 1, 2, 3, 0};

  initial begin
    vecs[0] = '{4'b0010, 4'b0000, ERR, 4'b0000};
    vecs[1] = '{4'b0010, 4'b0011, ERR, 4'b0000};
    vecs[2] = '{4'b0010, 4'b1100, MDP, 4'b1100};
    vecs[3] = '{4'b0010, 4'b1111, BDP, 4'b1101};
    vecs[4] = '{4'b0110, 4'b0001, ERR, 4'b0000};
    vecs[5] = '{4'b0001, 4'b0001, ERR, 4'b0000};
    vecs[6] = '{4'b1000, 4'b0011, MDP, 4'b0011};
    vecs[7] = '{4'b1000, 4'b1111, BDP, 4'b0111};
    vecs[8] = '{4'b0000, 4'b0100, ERR, 4'b0000};
    vecs[9] = '{4'b0100, 4'b1000, SDP, 4'b1000};

    // Reset state
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_type", 32'(out_type), 32'(ERR));
    chk("rst_pkt_ok", 32'(out_pkt_ok), 0);
    chk("rst_out_source", 32'(out_source), 0);
    chk("rst_out_target", 32'(out_target), 0);
    chk("rst_dest", 32'(out_dest_mask), 0);
    chk_cnts("rst_cnt", 0, 0, 0, 0);

    // Single SDP header, one-cycle latency
    out_ready = 1'b1;
    in_valid = 1'b1; in_source = 4'b0001; in_target = 4'b0100;
    tick();
    in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_type", 32'(out_type), 32'(SDP));
    chk("t1_ok", 32'(out_pkt_ok), 1);
    chk("t1_dest", 32'(out_dest_mask), 32'h4);
    chk_cnts("t1_cnt", 1, 0, 0, 0);

    // Classification table
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_source = vecs[i].src; in_target = vecs[i].tgt;
      tick();
`ifdef PKT_CLASSIFIER_DROP_ERR_EN
      if (vecs[i].typ == ERR) begin
        chk($sformatf("tbl%0d_dropped", i), 32'(out_valid), 0);
      end else begin
        chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 1);
        chk($sformatf("tbl%0d_type", i), 32'(out_type), 32'(vecs[i].typ));
        chk($sformatf("tbl%0d_ok", i), 32'(out_pkt_ok), 1);
        chk($sformatf("tbl%0d_dest", i), 32'(out_dest_mask), 32'(vecs[i].dest));
      end
`else
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("tbl%0d_type", i), 32'(out_type), 32'(vecs[i].typ));
      chk($sformatf("tbl%0d_ok", i), 32'(out_pkt_ok), 32'(vecs[i].typ != ERR));
      chk($sformatf("tbl%0d_dest", i), 32'(out_dest_mask), 32'(vecs[i].dest));
      chk($sformatf("tbl%0d_src", i), 32'(out_source), 32'(vecs[i].src));
`endif
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 1);
      if (i == 4) chk_cnts("tbl_sweep_cnt", 0, 1, 1, 3);
    end
    in_valid = 1'b0;
    tick();
    chk("tbl_idle_valid", 32'(out_valid), 0);
    chk_cnts("tbl_total_cnt", 1, 2, 2, 5);

    // Backpressure: stall output for 3 cycles with 4 headers pending
    do_reset();
    begin
      int idx;
      logic rdy;
      idx = 0;
      rdy = 1'b1;
      for (int k = 0; k < 7; k++) begin
        out_ready = bp_ordy[k];
        if (idx < 4) begin
          in_valid = 1'b1; in_source = hs[idx]; in_target = ht[idx];
        end else begin
          in_valid = 1'b0;
        end
        tick();
        if (idx < 4 && rdy) idx++;
        rdy = bp_rdy[k];
        chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'(bp_rdy[k]));
        chk($sformatf("bp%0d_valid", k), 32'(out_valid), 32'(bp_vld[k]));
        if (bp_vld[k]) begin
          chk($sformatf("bp%0d_src", k), 32'(out_source), 32'(hs[bp_idx[k]]));
          chk($sformatf("bp%0d_tgt", k), 32'(out_target), 32'(ht[bp_idx[k]]));
          chk($sformatf("bp%0d_dest", k), 32'(out_dest_mask), 32'(ht[bp_idx[k]]));
          chk($sformatf("bp%0d_type", k), 32'(out_type), 32'(SDP));
        end
      end
      in_valid = 1'b0;
      chk("bp_cnt_sdp", 32'(cnt_sdp), 4);
    end

    // Throughput: 8 back-to-back headers
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] t;
      t = 4'(4'b0010 << (i % 3));
      in_valid = 1'b1; in_source = 4'b0001; in_target = t;
      tick();
      chk($sformatf("tp%0d_in_ready", i), 32'(in_ready), 1);
      chk($sformatf("tp%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("tp%0d_tgt", i), 32'(out_target), 32'(t));
    end
    in_valid = 1'b0;
    tick();
    chk("tp_drain_valid", 32'(out_valid), 0);
    chk("tp_cnt_sdp", 32'(cnt_sdp), 8);

    // Counter saturation and clear priority
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_source = 4'b0001; in_target = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) chk("sat_at15", 32'(s_cnt_sdp), 15);
    end
    chk("sat_cnt4", 32'(s_cnt_sdp), 15);
    chk("sat_cnt16", 32'(cnt_sdp), 20);
    chk("sat_err4", 32'(s_cnt_err), 0);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    in_valid = 1'b0;
    chk("clr_cnt4", 32'(s_cnt_sdp), 0);
    chk("clr_cnt16", 32'(cnt_sdp), 0);
    tick();
    chk("clr_hold", 32'(cnt_sdp), 0);

    // Reset with output and skid both full
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_source = hs[0]; in_target = ht[0];
    tick();
    in_source = hs[1]; in_target = ht[1];
    tick();
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_valid", 32'(out_valid), 1);
    chk("full_cnt", 32'(cnt_sdp), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_cnt", 32'(cnt_sdp), 0);
    chk("flush_src", 32'(out_source), 0);
    chk("flush_type", 32'(out_type), 32'(ERR));
    out_ready = 1'b1;
    tick();
    chk("flush_no_stale0", 32'(out_valid), 0);
    tick();
    chk("flush_no_stale1", 32'(out_valid), 0);

    // 2-port instance: popcount 2 is BDP
    do_reset();
    d2_in_valid = 1'b1; d2_in_source = 2'b01; d2_in_target = 2'b10;
    tick();
    chk("p2_sdp_type", 32'(d2_out_type), 32'(SDP));
    chk("p2_sdp_dest", 32'(d2_out_dest_mask), 32'h2);
    d2_in_source = 2'b01; d2_in_target = 2'b11;
    tick();
    chk("p2_bdp_type", 32'(d2_out_type), 32'(BDP));
    chk("p2_bdp_dest", 32'(d2_out_dest_mask), 32'h2);
    d2_in_source = 2'b10; d2_in_target = 2'b11;
    tick();
    chk("p2_bdp2_dest", 32'(d2_out_dest_mask), 32'h1);
    chk("p2_bdp2_ok", 32'(d2_out_pkt_ok), 1);
    d2_in_valid = 1'b0;
    tick();
    chk("p2_idle", 32'(d2_out_valid), 0);
    chk("p2_cnt_bdp", 32'(d2_cnt_bdp), 2);
    chk("p2_cnt_mdp", 32'(d2_cnt_mdp), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
